// File: rtl/clkdiv_ctrl_pkg.sv
// Shared definitions for the clock-divider controller: FSM state encoding and
// divisor limits used by clkdiv_ctrl and clkdiv_core.
package clkdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam int MIN_DIV   = 2;
  localparam int DEF_WIDTH = 28;

endpackage

// File: rtl/clkdiv_core.sv
// Phase counter for the clock divider, plus the registered clock_out and tick.
// at_term flags the last cycle of the current period for the controller FSM.
module clkdiv_core #(
  parameter int WIDTH = 28
) (
  input  logic             clock_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] active_div,
  output logic             clock_out,
  output logic             tick,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;

  assign at_term = (count == active_div - ONE);

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      count     <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (enable) begin
        count <= at_term ? '0 : count + ONE;
      end
      // Low for the first half (rounded down) of the period, high for the rest.
      clock_out <= enable && (count >= (active_div >> 1));
      tick      <= enable && at_term;
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run/stop and reconfiguration controller for the programmable clock divider.
// Optional period counter output enabled by defining CLKDIV_CTRL_PERIOD_CNT_EN.
module clkdiv_ctrl
  import clkdiv_ctrl_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clock_in,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_divisor,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clock_out,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] active_div
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]      periods
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] div_d, shadow_q, shadow_d;
  logic             stop_pend_q, stop_pend_d;
  logic             err_d, at_term, xfer, div_ok;

  assign cfg_ready = (state_q != ST_PEND);
  assign running   = (state_q != ST_IDLE);
  assign xfer      = cfg_valid && cfg_ready;
  assign div_ok    = (cfg_divisor >= WIDTH'(MIN_DIV));

  clkdiv_core #(.WIDTH(WIDTH)) u_core (
    .clock_in   (clock_in),
    .rst        (rst),
    .enable     (state_q != ST_IDLE),
    .clear      (state_q == ST_IDLE),
    .active_div (active_div),
    .clock_out  (clock_out),
    .tick       (tick),
    .at_term    (at_term)
  );

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    div_d       = active_div;
    shadow_d    = shadow_q;
    stop_pend_d = stop_pend_q;
    err_d       = xfer && !div_ok;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer && div_ok) div_d = cfg_divisor;
        if (start && !stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop) stop_pend_d = 1'b1;
        // A divisor offered on the terminal cycle lands at this very boundary.
        if (xfer && div_ok) begin
          if (at_term) begin
            div_d = cfg_divisor;
          end else begin
            shadow_d = cfg_divisor;
            state_d  = ST_PEND;
          end
        end
        if (at_term && (stop || stop_pend_q)) begin
          state_d     = ST_IDLE;
          stop_pend_d = 1'b0;
        end
      end
      ST_PEND: begin
        if (stop) stop_pend_d = 1'b1;
        if (at_term) begin
          div_d = shadow_q;
          if (stop || stop_pend_q) begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      active_div  <= WIDTH'(DEFAULT_DIV);
      shadow_q    <= '0;
      stop_pend_q <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_div  <= div_d;
      shadow_q    <= shadow_d;
      stop_pend_q <= stop_pend_d;
      cfg_err     <= err_d;
    end
  end

`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  // Counts completed periods since the last start; frozen while idle.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      periods <= '0;
    end else if (state_q == ST_IDLE && state_d == ST_RUN) begin
      periods <= '0;
    end else if (state_q != ST_IDLE && at_term && periods != 16'hFFFF) begin
      periods <= periods + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: directed vector table, hand-built
// boundary sequences, and randomized traffic against a behavioural model.
module tb_clkdiv_ctrl;

  localparam int WIDTH       = 28;
  localparam int DEFAULT_DIV = 4;

  logic             clock_in = 1'b0;
  logic             rst, start, stop, cfg_valid;
  logic [WIDTH-1:0] cfg_divisor;
  logic             cfg_ready, cfg_err, clock_out, tick, running;
  logic [WIDTH-1:0] active_div;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  logic [15:0]      periods;
`endif

  clkdiv_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clock_in    (clock_in),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .cfg_valid   (cfg_valid),
    .cfg_divisor (cfg_divisor),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .clock_out   (clock_out),
    .tick        (tick),
    .running     (running),
    .active_div  (active_div)
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
    ,
    .periods     (periods)
`endif
  );

  always #5 clock_in = ~clock_in;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: position within the period, divisor in force, and a
  // queue holding at most one divisor waiting for the next boundary.
  bit m_run, m_stop, m_clk, m_tick, m_err;
  int m_pos, m_div, m_periods;
  int pend_q[$];

  task automatic model_step(input bit r, input bit s, input bit p, input bit v, input int d);
    bit last, xfer, ok;
    if (r) begin
      m_run = 0; m_stop = 0; m_pos = 0; m_div = DEFAULT_DIV; pend_q.delete();
      m_clk = 0; m_tick = 0; m_err = 0; m_periods = 0;
      return;
    end
    xfer   = v && (pend_q.size() == 0);
    ok     = (d >= 2);
    last   = m_run && (m_pos == m_div - 1);
    m_clk  = m_run && (m_pos >= m_div / 2);
    m_tick = last;
    m_err  = xfer && !ok;
    if (!m_run) begin
      if (xfer && ok) m_div = d;
      if (s && !p) begin m_run = 1; m_pos = 0; m_periods = 0; end
    end else begin
      if (p) m_stop = 1;
      if (xfer && ok) begin
        if (last) m_div = d;
        else pend_q.push_back(d);
      end
      if (last) begin
        if (pend_q.size() != 0) m_div = pend_q.pop_front();
        m_pos = 0;
        if (m_periods < 65535) m_periods++;
        if (m_stop) begin m_run = 0; m_stop = 0; end
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic compare_model();
    check("m_clock_out", clock_out, m_clk);
    check("m_tick", tick, m_tick);
    check("m_running", running, m_run);
    check("m_active_div", active_div, m_div);
    check("m_cfg_ready", cfg_ready, pend_q.size() == 0);
    check("m_cfg_err", cfg_err, m_err);
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
    check("m_periods", periods, m_periods);
`endif
  endtask

  // One clock: drive inputs, advance the model, sample 1 ns after the edge.
  task automatic cycle(input bit r, input bit s, input bit p, input bit v, input int d);
    rst = r; start = s; stop = p; cfg_valid = v; cfg_divisor = WIDTH'(d);
    model_step(r, s, p, v, d);
    @(posedge clock_in);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit start, stop, valid; int div;
    bit clk, tck, run, rdy, err; int adiv;
  } vec_t;
  vec_t vq[$];

  task automatic add(input bit s, input bit p, input bit v, input int d,
                     input bit c, input bit t, input bit rn, input bit rd, input bit e, input int ad);
    vec_t x;
    x = '{start:s, stop:p, valid:v, div:d, clk:c, tck:t, run:rn, rdy:rd, err:e, adiv:ad};
    vq.push_back(x);
  endtask

  initial begin : main
    bit [4:0] pat5;
    bit [7:0] pat8;
    bit       tck_last;

    // Divisor 1 rejected in IDLE, start at div 4, 4->6 reconfiguration, stop.
    add(0,0,1,1, 0,0,0,1,1,4);
    add(0,0,0,0, 0,0,0,1,0,4);
    add(1,0,0,0, 0,0,1,1,0,4);
    for (int k = 0; k < 8; k++)
      add(0,0,0,0, (k % 4) >= 2, (k % 4) == 3, 1,1,0,4);
    add(0,0,0,0, 0,0,1,1,0,4);
    add(0,0,1,6, 0,0,1,0,0,4);
    add(0,0,0,0, 1,0,1,0,0,4);
    add(0,0,0,0, 1,1,1,1,0,6);
    for (int k = 0; k < 6; k++)
      add(0,0,0,0, k >= 3, k == 5, 1,1,0,6);
    add(0,1,0,0, 0,0,1,1,0,6);
    add(0,0,0,0, 0,0,1,1,0,6);
    add(0,0,0,0, 0,0,1,1,0,6);
    add(0,0,0,0, 1,0,1,1,0,6);
    add(0,0,0,0, 1,0,1,1,0,6);
    add(0,0,0,0, 1,1,0,1,0,6);
    add(0,0,0,0, 0,0,0,1,0,6);
    add(1,1,0,0, 0,0,0,1,0,6);
    add(0,1,0,0, 0,0,0,1,0,6);

    cycle(1,0,0,0,0);
    check("reset_clock_out", clock_out, 0);
    check("reset_tick", tick, 0);
    check("reset_running", running, 0);
    check("reset_cfg_ready", cfg_ready, 1);
    check("reset_cfg_err", cfg_err, 0);
    check("reset_active_div", active_div, DEFAULT_DIV);

    foreach (vq[i]) begin
      cycle(0, vq[i].start, vq[i].stop, vq[i].valid, vq[i].div);
      check($sformatf("vec%0d_clock_out", i), clock_out, vq[i].clk);
      check($sformatf("vec%0d_tick", i), tick, vq[i].tck);
      check($sformatf("vec%0d_running", i), running, vq[i].run);
      check($sformatf("vec%0d_cfg_ready", i), cfg_ready, vq[i].rdy);
      check($sformatf("vec%0d_cfg_err", i), cfg_err, vq[i].err);
      check($sformatf("vec%0d_active_div", i), active_div, vq[i].adiv);
    end

    // Div 5, stop at count 2: period completes low 2 / high 3, then idle.
    cycle(1,0,0,0,0);
    cycle(0,0,0,1,5);
    cycle(0,1,0,0,0);
    for (int i = 0; i < 5; i++) begin
      cycle(0,0,(i == 2),0,0);
      pat5[4-i] = clock_out;
      tck_last  = tick;
    end
    check("div5_stop_pattern", pat5, 5'b00111);
    check("div5_stop_tick", tck_last, 1);
    check("div5_stop_running", running, 0);
    cycle(0,0,0,0,0);
    check("div5_idle_clock_out", clock_out, 0);

    // Divisor 8 and stop together at count 0 of div 4: 8 applied, then stop.
    cycle(0,0,0,1,4);
    cycle(0,1,0,0,0);
    cycle(0,0,1,1,8);
    check("pend_cfg_ready", cfg_ready, 0);
    for (int i = 0; i < 3; i++) cycle(0,0,0,0,0);
    check("stop8_active_div", active_div, 8);
    check("stop8_running", running, 0);
    cycle(0,1,0,0,0);
    for (int i = 0; i < 8; i++) begin
      cycle(0,0,0,0,0);
      pat8[7-i] = clock_out;
    end
    check("div8_pattern", pat8, 8'b00001111);
    check("div8_tick", tick, 1);

    // Reset while a divisor is pending.
    cycle(0,0,0,1,3);
    check("pend3_cfg_ready", cfg_ready, 0);
    cycle(1,0,0,0,0);
    check("rst_pend_running", running, 0);
    check("rst_pend_active_div", active_div, DEFAULT_DIV);
    check("rst_pend_cfg_ready", cfg_ready, 1);
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
    cycle(0,1,0,0,0);
    for (int i = 0; i < 12; i++) cycle(0,0,0,0,0);
    check("periods_after_3", periods, 3);
    cycle(0,0,1,0,0);
    for (int i = 0; i < 3; i++) cycle(0,0,0,0,0);
    cycle(0,1,0,0,0);
    check("periods_restart", periods, 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 9)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
